// File: rtl/mips_pkg.sv
//==============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the instruction fetch slice: MIPS
//               opcode / funct constants, fetch FSM state encoding and the
//               default reset PC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/next_pc_logic.sv
//==============================================================================
// Module      : next_pc_logic
// Description : Pure combinational next-PC selection.
//               Ports:
//                 pc         in  32  current instruction address
//                 instr_idx  in  26  jump index field (instr[25:0])
//                 signimm_lo in  30  signimm[29:0]; upper bits shift out
//                 jump       in   1  j instruction (priority over branch)
//                 branch     in   1  beq instruction
//                 zero       in   1  ALU zero flag
//                 pc_plus4   out 32  pc + 4, wraps modulo 2^32
//                 next_pc    out 32  selected successor address
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module next_pc_logic (
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [29:0] signimm_lo,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  // Plain 32-bit adds: carries out of bit 31 are discarded, giving the wrap.
  assign pc_plus4        = pc + 32'd4;
  assign w_branch_target = pc_plus4 + {signimm_lo, 2'b00};
  // Jump stays inside the 256 MB region of the delay-slot address.
  assign w_jump_target   = {pc_plus4[31:28], instr_idx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = w_jump_target;
    end else if (branch && zero) begin
      next_pc = w_branch_target;
    end
  end

endmodule : next_pc_logic

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//==============================================================================
// Module      : instr_fetch_unit
// Description : Holds the PC, fetches one word per instruction over a
//               variable-latency req/ready port and presents the instruction
//               to decode. Commits the next PC when the datapath retires.
//               Ports:
//                 clk, rst_n            clock / synchronous active-low reset
//                 imem_req/addr (out)   fetch request, address = pc
//                 imem_ready/rdata (in) fetch completion and data
//                 jump/branch/zero/signimm (in) next-PC controls
//                 retire (in)           commit next PC (EXEC only)
//                 instr/opcode/funct    instruction register and fields
//                 instr_valid           high in EXEC
//                 pc/pc_plus4           current address and its successor
//                 retired_cnt           wrapping retire counter
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] signimm,
  input  logic        retire,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_cnt
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         r_imem_req;
  logic [31:0]  r_retired_cnt;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;

  // signimm[31:30] are shifted out of the branch offset.
  logic         w_unused_signimm_hi;
  assign w_unused_signimm_hi = &{1'b0, signimm[31:30]};

  next_pc_logic u_next_pc (
    .pc         (r_pc),
    .instr_idx  (r_instr[25:0]),
    .signimm_lo (signimm[29:0]),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .pc_plus4   (w_pc_plus4),
    .next_pc    (w_next_pc)
  );

  // imem_req and instr_valid are registered alongside the state so they are
  // glitch-free and never depend combinationally on imem_ready/imem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RST;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_retired_cnt <= 32'h0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_state       <= ST_EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + 32'd1;
            r_state       <= ST_FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_RST;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign retired_cnt = r_retired_cnt;

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//==============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. A second
//               instance with RESET_PC = 32'hFFFF_FFFC shares the stimulus and
//               exercises the PC wrap-around.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] signimm;
  logic        retire;

  logic        imem_req,    w_imem_req;
  logic [31:0] imem_addr,   w_imem_addr;
  logic [31:0] instr,       w_instr;
  logic [5:0]  opcode,      w_opcode;
  logic [5:0]  funct,       w_funct;
  logic        instr_valid, w_instr_valid;
  logic [31:0] pc,          w_pc;
  logic [31:0] pc_plus4,    w_pc_plus4;
  logic [31:0] retired_cnt, w_retired_cnt;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .signimm     (signimm),
    .retire      (retire),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .signimm     (signimm),
    .retire      (retire),
    .instr       (w_instr),
    .opcode      (w_opcode),
    .funct       (w_funct),
    .instr_valid (w_instr_valid),
    .pc          (w_pc),
    .pc_plus4    (w_pc_plus4),
    .retired_cnt (w_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-cycle fetch followed by one EXEC cycle with retire.
  task automatic do_instr(input logic [31:0] word, input logic j, input logic b,
                          input logic z, input logic [31:0] si);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    jump = j; branch = b; zero = z; signimm = si;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; signimm = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; signimm = 32'h0; retire = 1'b0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_pc",          pc,              32'h0);
    chk("rst_valid",       {31'h0, instr_valid}, 32'h0);
    chk("rst_req",         {31'h0, imem_req},    32'h0);
    chk("rst_cnt",         retired_cnt,     32'h0);
    chk("rst_instr",       instr,           32'h0);
    chk("wrap_rst_pc",     w_pc,            32'hFFFF_FFFC);
    chk("wrap_rst_plus4",  w_pc_plus4,      32'h0);

    // Release: RST cycle, then FETCH with request raised
    rst_n = 1'b1;
    tick();
    chk("rel_req",  {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Three wait cycles; retire during FETCH must be ignored
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      tick();
      chk("wait_addr", imem_addr, 32'h0);
      chk("wait_req",  {31'h0, imem_req}, 32'h1);
      chk("wait_cnt",  retired_cnt, 32'h0);
    end
    retire = 1'b0;
    chk("wrap_fetch_retire_ignored", w_pc, 32'hFFFF_FFFC);
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ready = 1'b0;
    chk("exec_valid",  {31'h0, instr_valid}, 32'h1);
    chk("exec_req",    {31'h0, imem_req},    32'h0);
    chk("exec_instr",  instr,               32'h2008_0005);
    chk("exec_opcode", {26'h0, opcode},     32'h08);
    chk("exec_funct",  {26'h0, funct},      32'h05);
    chk("exec_plus4",  pc_plus4,            32'h4);

    // imem_ready during EXEC must not disturb instr
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    chk("exec_ready_ignored", instr, 32'h2008_0005);

    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("seq_pc4",     pc,          32'h4);
    chk("seq_cnt1",    retired_cnt, 32'h1);
    chk("seq_valid0",  {31'h0, instr_valid}, 32'h0);
    chk("seq_req1",    {31'h0, imem_req},    32'h1);
    chk("wrap_pc0",    w_pc,        32'h0);

    // One-cycle fetch
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ready = 1'b0;
    chk("fast_fetch_valid", {31'h0, instr_valid}, 32'h1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("seq_pc8",  pc,          32'h8);
    chk("seq_cnt2", retired_cnt, 32'h2);

    // Walk to 0x10
    do_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    do_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc_0x10", pc, 32'h10);

    // beq taken backwards: 0x14 + (-2 << 2) = 0x0C
    do_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("beq_taken", pc, 32'h0C);
    do_instr(32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("back_0x10", pc, 32'h10);
    // beq not taken
    do_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("beq_not_taken", pc, 32'h14);
    // Far branch: 0x18 + (0x0800_000A << 2 = 0x2000_0028) = 0x2000_0040
    do_instr(32'h1000_000A, 1'b0, 1'b1, 1'b1, 32'h0800_000A);
    chk("beq_far", pc, 32'h2000_0040);

    // Jump with branch/zero also high: jump wins
    imem_ready = 1'b1; imem_rdata = 32'h0800_0100;
    tick();
    imem_ready = 1'b0;
    chk("j_opcode", {26'h0, opcode}, 32'h02);
    chk("j_plus4",  pc_plus4,        32'h2000_0044);
    jump = 1'b1; branch = 1'b1; zero = 1'b1; signimm = 32'hFFFF_FFFE;
    retire = 1'b1;
    tick();
    retire = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0; signimm = 32'h0;
    chk("j_target", pc,          32'h2000_0400);
    chk("j_cnt",    retired_cnt, 32'd9);

    // Reset while a fetch is outstanding
    tick();
    chk("midfetch_req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("midrst_pc",    pc,          32'h0);
    chk("midrst_cnt",   retired_cnt, 32'h0);
    chk("midrst_req",   {31'h0, imem_req},    32'h0);
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_instr", instr,       32'h0);
    chk("wrap_midrst_pc", w_pc,      32'hFFFF_FFFC);

    // Late ready in the RST cycle is not captured
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    chk("late_ready_instr", instr, 32'h0);
    chk("late_ready_valid", {31'h0, instr_valid}, 32'h0);
    chk("late_ready_req",   {31'h0, imem_req},    32'h1);
    chk("late_ready_addr",  imem_addr,            32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch_unit

`default_nettype wire
